// File: rtl/parking_allocator.sv
// Parking lot allocator: grants the lowest free space on a gate request,
// rejects when full, and blinks spaces for a fixed hold time while they
// are being vacated before returning them to the free pool.
module parking_allocator #(
  parameter int FLICKER_DIV = 4,
  parameter int LEAVE_HOLD  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power,
  input  logic        req,
  input  logic [7:0]  leave,
  output logic        grant,
  output logic [2:0]  grant_idx,
  output logic        reject,
  output logic [7:0]  occupied,
  output logic [3:0]  count,
  output logic        full,
  output logic [15:0] led
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    REJECT   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       leaving;
  logic [7:0][3:0]  hold;
  logic [7:0]       div;
  logic             flicker;
  logic             grant_r;
  logic             reject_r;
  logic [2:0]       free_idx;
  logic             have_free;

  // Lowest-index free space from registered occupancy. A leaving space is
  // still occupied, so it is never picked, and a space freed this edge only
  // shows up as free for the next decision.
  always_comb begin
    free_idx  = 3'd0;
    have_free = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!occupied[i]) begin
        free_idx  = 3'(i);
        have_free = 1'b1;
      end
    end
  end

  // Handshake FSM, per-space hold counters and flicker divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      occupied  <= '0;
      leaving   <= '0;
      hold      <= '0;
      div       <= '0;
      flicker   <= 1'b0;
      grant_r   <= 1'b0;
      reject_r  <= 1'b0;
      grant_idx <= '0;
    end else if (!power) begin
      state     <= IDLE;
      occupied  <= '0;
      leaving   <= '0;
      hold      <= '0;
      div       <= '0;
      flicker   <= 1'b0;
      grant_r   <= 1'b0;
      reject_r  <= 1'b0;
      grant_idx <= '0;
    end else begin
      if (div == 8'(FLICKER_DIV - 1)) begin
        div     <= '0;
        flicker <= ~flicker;
      end else begin
        div <= div + 8'd1;
      end

      // A leave pulse only arms an occupied space that is not already
      // counting down; re-pulsing during the hold is ignored.
      for (int i = 0; i < 8; i++) begin
        if (leaving[i]) begin
          hold[i] <= hold[i] - 4'd1;
          if (hold[i] == 4'd1) begin
            leaving[i]  <= 1'b0;
            occupied[i] <= 1'b0;
          end
        end else if (leave[i] && occupied[i]) begin
          leaving[i] <= 1'b1;
          hold[i]    <= 4'(LEAVE_HOLD);
        end
      end

      grant_r  <= 1'b0;
      reject_r <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (have_free) begin
              state              <= GRANT;
              grant_r            <= 1'b1;
              grant_idx          <= free_idx;
              occupied[free_idx] <= 1'b1;
            end else begin
              state    <= REJECT;
              reject_r <= 1'b1;
            end
          end
        end
        GRANT, REJECT: state <= WAIT_REL;
        WAIT_REL: if (!req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pulses are suppressed as soon as power drops, not one edge later.
  assign grant  = grant_r & power;
  assign reject = reject_r & power;

  // Occupancy count and display vector.
  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) count = count + {3'b000, occupied[i]};
  end

  assign full = (count == 4'd8);
  assign led  = {full, 3'b000, count, occupied & ~(leaving & {8{~flicker}})};

endmodule

// File: tb/tb_parking_allocator.sv
// Self-checking bench for parking_allocator: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural lot model.
module tb_parking_allocator;
  localparam int FD = 4;
  localparam int LH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        power = 1'b0;
  logic        req = 1'b0;
  logic [7:0]  leave = '0;
  logic        grant;
  logic [2:0]  grant_idx;
  logic        reject;
  logic [7:0]  occupied;
  logic [3:0]  count;
  logic        full;
  logic [15:0] led;

  int n_tests = 0;
  int n_fail  = 0;

  parking_allocator #(.FLICKER_DIV(FD), .LEAVE_HOLD(LH)) dut (
    .clk(clk), .rst(rst), .power(power), .req(req), .leave(leave),
    .grant(grant), .grant_idx(grant_idx), .reject(reject),
    .occupied(occupied), .count(count), .full(full), .led(led)
  );

  always #5 clk = ~clk;

  // Behavioural model: a lot of 8 spaces, each with remaining hold time
  // (0 = not vacating), plus the gate's handshake phase.
  bit m_occ[8];
  int m_hold[8];
  int m_phase;   // 0 ready, 1 granted, 2 rejected, 3 waiting for release
  int m_gidx;
  int m_div;
  bit m_flick;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_occ[i] = 0; m_hold[i] = 0; end
    m_phase = 0; m_gidx = 0; m_div = 0; m_flick = 0;
  endtask

  // One rising edge of the lot, using the inputs presented before it.
  task automatic model_step();
    bit old_occ[8];
    int pick;
    if (!power) begin model_reset(); return; end
    old_occ = m_occ;
    for (int i = 0; i < 8; i++) begin
      if (m_hold[i] > 0) begin
        m_hold[i]--;
        if (m_hold[i] == 0) m_occ[i] = 0;
      end else if (leave[i] && old_occ[i]) begin
        m_hold[i] = LH;
      end
    end
    if (m_phase == 0) begin
      if (req) begin
        pick = -1;
        for (int i = 7; i >= 0; i--) if (!old_occ[i]) pick = i;
        if (pick >= 0) begin m_phase = 1; m_gidx = pick; m_occ[pick] = 1; end
        else m_phase = 2;
      end
    end else if (m_phase == 3) begin
      if (!req) m_phase = 0;
    end else begin
      m_phase = 3;
    end
    m_div++;
    if (m_div == FD) begin m_div = 0; m_flick = !m_flick; end
  endtask

  task automatic check_all();
    int n;
    logic [7:0] occ_v, led_lo;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      occ_v[i]  = m_occ[i];
      led_lo[i] = m_occ[i] && !(m_hold[i] > 0 && !m_flick);
      n += int'(m_occ[i]);
    end
    chk("grant",     32'(grant),     32'(m_phase == 1 && power));
    chk("reject",    32'(reject),    32'(m_phase == 2 && power));
    chk("grant_idx", 32'(grant_idx), 32'(m_gidx));
    chk("occupied",  32'(occupied),  32'(occ_v));
    chk("count",     32'(count),     32'(n));
    chk("full",      32'(full),      32'(n == 8));
    chk("led",       32'(led),       {16'h0, n == 8, 3'b000, 4'(n), led_lo});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  // Asynchronous reset pulse between edges: outputs must clear at once.
  task automatic pulse_rst();
    rst = 1'b1;
    #1 model_reset();
    check_all();
    rst = 1'b0;
  endtask

  task automatic handshake();
    req = 1'b1; cyc();
    req = 1'b0; cyc(); cyc();
  endtask

  initial begin
    model_reset();
    #2 pulse_rst();
    chk("rst_led", 32'(led), 32'h0);
    power = 1'b1;
    cyc();

    // First request: space 0.
    req = 1'b1; cyc();
    chk("first_grant", 32'(grant), 32'd1);
    chk("first_led", 32'(led), 32'h0101);
    req = 1'b0; cyc(); cyc();

    // Fill the lot, then a request is rejected.
    for (int k = 0; k < 7; k++) handshake();
    req = 1'b1; cyc();
    chk("full_reject", 32'(reject), 32'd1);
    chk("full_led_hi", 32'(led[15:8]), 32'h88);
    req = 1'b0; cyc(); cyc();

    // Leave on space 5 together with a request while full: still rejected.
    leave = 8'h20; req = 1'b1; cyc();
    chk("leave_req_reject", 32'(reject), 32'd1);
    leave = 8'h00; req = 1'b0;
    for (int k = 0; k < 12; k++) cyc();

    // Three parked spaces, vacate space 1, re-pulse its leave mid-hold.
    pulse_rst();
    for (int k = 0; k < 3; k++) handshake();
    chk("three_parked", 32'(occupied), 32'h07);
    leave = 8'h02; cyc();
    leave = 8'h00;
    for (int k = 0; k < 4; k++) cyc();
    leave = 8'h02; cyc();
    leave = 8'h00;
    cyc(); cyc();
    chk("still_held", 32'(occupied), 32'h07);
    cyc();
    chk("freed_after_hold", 32'(occupied), 32'h05);
    req = 1'b1; cyc();
    chk("refill_idx", 32'(grant_idx), 32'd1);

    // Held request: one grant only.
    for (int k = 0; k < 20; k++) cyc();
    req = 1'b0; cyc(); cyc();

    // Power dropped mid-wait clears everything; next grant is space 0.
    req = 1'b1; cyc(); cyc();
    power = 1'b0; cyc();
    chk("power_off_occ", 32'(occupied), 32'h0);
    power = 1'b1; req = 1'b0; cyc();
    req = 1'b1; cyc();
    chk("after_power_idx", 32'(grant_idx), 32'd0);
    req = 1'b0; cyc(); cyc();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      req   = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < 8; i++) leave[i] = ($urandom_range(0, 15) == 0);
      power = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 299) == 0) pulse_rst();
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
